// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the execute/result side of the pipeline.
//   - ALU opcode (aluc) constants
//   - branch-type codes
//   - result-stage skid buffer state encoding
//   - helper that recognises the set-less-than opcodes
package cpu_pkg;

    localparam logic [4:0] ALUC_ADDU = 5'b00000;
    localparam logic [4:0] ALUC_SUBU = 5'b00001;
    localparam logic [4:0] ALUC_AND  = 5'b00010;
    localparam logic [4:0] ALUC_OR   = 5'b00011;
    localparam logic [4:0] ALUC_XOR  = 5'b00100;
    localparam logic [4:0] ALUC_NOR  = 5'b00101;
    localparam logic [4:0] ALUC_SLL  = 5'b00110;
    localparam logic [4:0] ALUC_SRL  = 5'b00111;
    localparam logic [4:0] ALUC_SRA  = 5'b01000;
    localparam logic [4:0] ALUC_LUI  = 5'b01001;
    localparam logic [4:0] ALUC_SLT  = 5'b01010;
    localparam logic [4:0] ALUC_SLTU = 5'b01011;
    localparam logic [4:0] ALUC_MUL  = 5'b01100;

    // 2'b11 is reserved and behaves like BR_NONE.
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_HALF  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    function automatic logic is_set_less(input logic [4:0] aluc);
        return (aluc == ALUC_SLT) || (aluc == ALUC_SLTU);
    endfunction

endpackage

// File: rtl/ex_result_format.sv
// Combinational formatting of one ALU result entry.
// Ports:
//   i_alu_res, i_alu_zero, i_alu_sign, i_aluc : ALU result, flags and opcode
//   i_br_type, i_pc_plus4, i_imm16            : branch control and operands
//   i_rd, i_reg_we                            : destination and write request
//   o_wb_data   : alu_res, or the 0/1 compare word for SLT/SLTU
//   o_br_taken  : BEQ/BNE resolution from the zero flag
//   o_br_target : pc_plus4 + sign-extended word offset (wraps)
//   o_wb_we     : write enable, suppressed for register 0
module ex_result_format
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic [DATA_W-1:0] i_alu_res,
    input  logic              i_alu_zero,
    input  logic              i_alu_sign,
    input  logic [4:0]        i_aluc,
    input  logic [1:0]        i_br_type,
    input  logic [DATA_W-1:0] i_pc_plus4,
    input  logic [15:0]       i_imm16,
    input  logic [REG_W-1:0]  i_rd,
    input  logic              i_reg_we,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_br_taken,
    output logic [DATA_W-1:0] o_br_target,
    output logic              o_wb_we
);

    // Word offset: sign-extend and scale by 4 in one concatenation.
    logic [DATA_W-1:0] w_offset;

    assign w_offset    = {{(DATA_W-18){i_imm16[15]}}, i_imm16, 2'b00};
    assign o_br_target = i_pc_plus4 + w_offset;

    assign o_wb_data   = is_set_less(i_aluc) ? {{(DATA_W-1){1'b0}}, i_alu_sign}
                                             : i_alu_res;

    assign o_br_taken  = ((i_br_type == BR_BEQ) &  i_alu_zero)
                       | ((i_br_type == BR_BNE) & ~i_alu_zero);

    assign o_wb_we     = i_reg_we & (i_rd != '0);

endmodule

// File: rtl/ex_result_stage.sv
// Result stage behind the ALU: formats each entry and hands it to MEM/WB
// through a valid/ready handshake backed by a 2-entry skid buffer, so that
// in_ready is a flop and never depends combinationally on out_ready.
// Ports:
//   clk, rst (sync, active high), flush
//   upstream   : in_valid, in_ready, alu_*, aluc, br_type, pc_plus4, imm16, rd, reg_we
//   downstream : out_valid, out_ready, wb_data, wb_rd, wb_we, br_taken,
//                br_target, carry_out
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing held, out_valid=0
// ST_HALF  | output register holds the oldest entry
// ST_FULL  | output register + skid register both hold entries, in_ready=0
module ex_result_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_sign,
    input  logic [4:0]        aluc,
    input  logic [1:0]        br_type,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [15:0]       imm16,
    input  logic [REG_W-1:0]  rd,
    input  logic              reg_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_we,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              carry_out
);

    // Packed entry: {carry, br_target, br_taken, wb_we, rd, wb_data}
    localparam int BW = 2*DATA_W + REG_W + 3;

    logic [DATA_W-1:0] w_wb_data;
    logic [DATA_W-1:0] w_br_target;
    logic              w_br_taken;
    logic              w_wb_we;
    logic [BW-1:0]     w_fmt;

    logic [1:0]        r_state;
    logic              r_in_ready;
    logic [BW-1:0]     r_out;
    logic [BW-1:0]     r_skid;

    logic              w_accept;
    logic              w_drain;
    logic [1:0]        w_state_nxt;
    logic              w_load_out;
    logic              w_load_skid;
    logic [BW-1:0]     w_out_src;

    ex_result_format #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_format (
        .i_alu_res   (alu_res),
        .i_alu_zero  (alu_zero),
        .i_alu_sign  (alu_sign),
        .i_aluc      (aluc),
        .i_br_type   (br_type),
        .i_pc_plus4  (pc_plus4),
        .i_imm16     (imm16),
        .i_rd        (rd),
        .i_reg_we    (reg_we),
        .o_wb_data   (w_wb_data),
        .o_br_taken  (w_br_taken),
        .o_br_target (w_br_target),
        .o_wb_we     (w_wb_we)
    );

    assign w_fmt     = {alu_carry, w_br_target, w_br_taken, w_wb_we, rd, w_wb_data};

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid & r_in_ready;
    assign w_drain   = out_valid & out_ready;

    assign {carry_out, br_target, br_taken, wb_we, wb_rd, wb_data} = r_out;

    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_out_src   = w_fmt;
        // A flush still lets a same-cycle drain complete downstream; the
        // stage simply ends up empty and holds its data registers.
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_HALF;
                        w_load_out  = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (w_accept && w_drain) begin
                        w_load_out  = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_state_nxt = ST_HALF;
                        w_load_out  = 1'b1;
                        w_out_src   = r_skid;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_out      <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
            if (w_load_out) begin
                r_out <= w_out_src;
            end
            if (w_load_skid) begin
                r_skid <= w_fmt;
            end
        end
    end

endmodule

// File: tb/tb_ex_result_stage.sv
module tb_ex_result_stage;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        logic [31:0] tgt;
        logic        carry;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_sign;
    logic [4:0]  aluc;
    logic [1:0]  br_type;
    logic [31:0] pc_plus4;
    logic [15:0] imm16;
    logic [4:0]  rd;
    logic        reg_we;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        br_taken;
    logic [31:0] br_target;
    logic        carry_out;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t model[$];
    bit   zero_exp;

    ex_result_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_res   (alu_res),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .alu_sign  (alu_sign),
        .aluc      (aluc),
        .br_type   (br_type),
        .pc_plus4  (pc_plus4),
        .imm16     (imm16),
        .rd        (rd),
        .reg_we    (reg_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd),
        .wb_we     (wb_we),
        .br_taken  (br_taken),
        .br_target (br_target),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference formatting straight from the rules, using integer arithmetic.
    function automatic exp_t fmt();
        exp_t e;
        int   off;
        if (aluc == 5'b01010 || aluc == 5'b01011) e.data = alu_sign ? 32'd1 : 32'd0;
        else                                      e.data = alu_res;
        e.rd    = rd;
        e.we    = reg_we && (rd != 5'd0);
        if (br_type == 2'b01)      e.taken = alu_zero;
        else if (br_type == 2'b10) e.taken = !alu_zero;
        else                       e.taken = 1'b0;
        off   = int'($signed(imm16));
        e.tgt = pc_plus4 + 32'(off * 4);
        e.carry = alu_carry;
        return e;
    endfunction

    task automatic check_outputs();
        exp_t e;
        chk("in_ready", {31'b0, in_ready}, {31'b0, model.size() < 2});
        chk("out_valid", {31'b0, out_valid}, {31'b0, model.size() > 0});
        if (model.size() > 0) begin
            e = model[0];
            chk("wb_data", wb_data, e.data);
            chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
            chk("wb_we", {31'b0, wb_we}, {31'b0, e.we});
            chk("br_taken", {31'b0, br_taken}, {31'b0, e.taken});
            chk("br_target", br_target, e.tgt);
            chk("carry_out", {31'b0, carry_out}, {31'b0, e.carry});
        end else if (zero_exp) begin
            chk("rst_data", wb_data, 32'd0);
            chk("rst_target", br_target, 32'd0);
            chk("rst_flags", {27'b0, wb_rd, wb_we, br_taken, carry_out}, 32'd0);
        end
    endtask

    // One clock: check at negedge, advance the queue model at posedge.
    task automatic cycle();
        bit acc;
        bit drn;
        @(negedge clk);
        check_outputs();
        acc = in_valid && (model.size() < 2);
        drn = (model.size() > 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            model.delete();
            zero_exp = 1'b1;
        end else begin
            if (drn) model.delete(0);
            if (flush) model.delete();
            else if (acc) begin
                model.push_back(fmt());
                zero_exp = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] res,
                         input logic sgn, input logic zr, input logic [1:0] bt,
                         input logic [31:0] pc, input logic [15:0] imm,
                         input logic [4:0] r, input logic we);
        in_valid  = v;
        aluc      = a;
        alu_res   = res;
        alu_sign  = sgn;
        alu_zero  = zr;
        alu_carry = res[0];
        br_type   = bt;
        pc_plus4  = pc;
        imm16     = imm;
        rd        = r;
        reg_we    = we;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, 5'($urandom_range(0, 12)), $urandom, 1'($urandom), 1'($urandom),
              2'($urandom), $urandom, 16'($urandom), 5'($urandom), 1'($urandom));
        alu_carry = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 16'd0, 5'd0, 1'b0);
        zero_exp = 1'b1;
        @(posedge clk); #1;
        cycle();
        rst = 1'b0;
        cycle();

        // pass-through
        drive(1'b1, 5'b00000, 32'h0000_1234, 1'b0, 1'b0, 2'b00, 32'h100, 16'h1, 5'd3, 1'b1);
        cycle();
        chk("pt_valid", {31'b0, out_valid}, 32'd1);
        chk("pt_data", wb_data, 32'h0000_1234);
        chk("pt_rd", {27'b0, wb_rd}, 32'd3);
        chk("pt_we", {31'b0, wb_we}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive_rand(1'b1);
            cycle();
        end

        // set-less-than formatting
        drive(1'b1, 5'b01010, 32'hFFFF_FFFB, 1'b1, 1'b0, 2'b00, 32'h0, 16'h0, 5'd4, 1'b1);
        cycle();
        chk("slt_data", wb_data, 32'h0000_0001);
        drive(1'b1, 5'b01011, 32'hFFFF_FFFB, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0, 5'd4, 1'b1);
        cycle();
        chk("sltu_data", wb_data, 32'h0000_0000);

        // branches
        drive(1'b1, 5'b00001, 32'h0, 1'b0, 1'b1, 2'b01, 32'h0040_0010, 16'hFFFC, 5'd0, 1'b0);
        cycle();
        chk("beq_taken", {31'b0, br_taken}, 32'd1);
        chk("beq_target", br_target, 32'h0040_0000);
        drive(1'b1, 5'b00001, 32'h0, 1'b0, 1'b1, 2'b10, 32'h0040_0010, 16'hFFFC, 5'd0, 1'b0);
        cycle();
        chk("bne_taken", {31'b0, br_taken}, 32'd0);
        drive(1'b1, 5'b00001, 32'h0, 1'b0, 1'b0, 2'b10, 32'hFFFF_FFF0, 16'h0008, 5'd0, 1'b0);
        cycle();
        chk("bne_wrap", br_target, 32'h0000_0010);

        // backpressure: A, B, C with out_ready low
        in_valid = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b0;
        drive(1'b1, 5'b00000, 32'hA, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0, 5'd1, 1'b1);
        cycle();
        drive(1'b1, 5'b00000, 32'hB, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0, 5'd2, 1'b1);
        cycle();
        drive(1'b1, 5'b00000, 32'hC, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0, 5'd3, 1'b1);
        cycle();
        chk("bp_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_head_a", wb_data, 32'hA);
        cycle();
        chk("bp_hold_a", wb_data, 32'hA);
        out_ready = 1'b1;
        cycle();
        chk("bp_b", wb_data, 32'hB);
        cycle();
        chk("bp_c", wb_data, 32'hC);
        in_valid = 1'b0;
        cycle();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // flush from FULL with a new offer
        out_ready = 1'b0;
        drive_rand(1'b1);
        cycle();
        drive_rand(1'b1);
        cycle();
        flush = 1'b1;
        drive(1'b1, 5'b00000, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0, 5'd7, 1'b1);
        cycle();
        flush = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("fl_gone", {31'b0, out_valid}, 32'd0);

        // reset from FULL
        out_ready = 1'b0;
        drive_rand(1'b1);
        cycle();
        drive_rand(1'b1);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rs_valid", {31'b0, out_valid}, 32'd0);
        chk("rs_ready", {31'b0, in_ready}, 32'd1);
        chk("rs_data", wb_data, 32'd0);
        chk("rs_target", br_target, 32'd0);
        chk("rs_flags", {27'b0, wb_rd, wb_we, br_taken, carry_out}, 32'd0);

        // rd == 0 suppresses the write
        out_ready = 1'b1;
        drive(1'b1, 5'b00000, 32'h55, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0, 5'd0, 1'b1);
        cycle();
        chk("rd0_we", {31'b0, wb_we}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'($urandom_range(0, 3) != 0));
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
